// File: rtl/fu_wb_pkg.sv
// Shared types and defaults for the FU writeback collector.
package fu_wb_pkg;

    localparam int unsigned FuWbDepth    = 4;
    localparam int unsigned FuWbXlen     = 32;
    localparam int unsigned FuWbTransIdW = 3;

    typedef struct packed {
        logic [FuWbXlen-1:0]     result;
        logic [FuWbTransIdW-1:0] trans_id;
    } fu_wb_entry_t;

endpackage

// File: rtl/fu_wb_fifo.sv
// DEPTH-entry flop FIFO of writeback entries with synchronous flush.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fu_wb_fifo
    import fu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = FuWbDepth
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  fu_wb_entry_t               data_i,
    output fu_wb_entry_t               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fu_wb_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fu_wb_collector.sv
// Buffers fixed-latency FU results and replays them onto the writeback port under valid/ack.
// Optional zero-latency bypass when the FIFO is empty: define FU_WB_COLLECTOR_BYPASS_EN.
module fu_wb_collector
    import fu_wb_pkg::*;
#(
    parameter int unsigned DEPTH      = FuWbDepth,
    parameter int unsigned XLEN       = FuWbXlen,
    parameter int unsigned TRANS_ID_W = FuWbTransIdW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic                       fu_valid_i,
    input  logic [XLEN-1:0]            fu_result_i,
    input  logic [TRANS_ID_W-1:0]      fu_trans_id_i,
    output logic                       wb_valid_o,
    output logic [XLEN-1:0]            wb_result_o,
    output logic [TRANS_ID_W-1:0]      wb_trans_id_o,
    input  logic                       wb_ack_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned UsedW = CntW + 1;
    localparam logic [UsedW-1:0] DepthC = UsedW'(DEPTH);

    logic [CntW-1:0]  inflight_q, inflight_d, fifo_count;
    logic [UsedW-1:0] used;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             issue_fire, violation, overflow_q;
    fu_wb_entry_t     fifo_din, fifo_dout;

    // Credits cover both buffered and in-flight results, so the FU can never overrun the FIFO.
    assign used          = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign issue_ready_o = (used < DepthC) & ~flush_i;
    assign issue_fire    = issue_valid_i & issue_ready_o;

    assign fifo_din.result   = fu_result_i;
    assign fifo_din.trans_id = fu_trans_id_i;

`ifdef FU_WB_COLLECTOR_BYPASS_EN
    logic bypass;
    assign bypass        = fifo_empty & fu_valid_i & ~flush_i;
    assign wb_valid_o    = (~fifo_empty | fu_valid_i) & ~flush_i;
    assign wb_result_o   = bypass ? fu_result_i : fifo_dout.result;
    assign wb_trans_id_o = bypass ? fu_trans_id_i : fifo_dout.trans_id;
    // An entry acked straight off the FU never occupies a slot.
    assign fifo_push     = fu_valid_i & ~flush_i & ~(bypass & wb_ack_i);
`else
    assign wb_valid_o    = ~fifo_empty & ~flush_i;
    assign wb_result_o   = fifo_dout.result;
    assign wb_trans_id_o = fifo_dout.trans_id;
    assign fifo_push     = fu_valid_i & ~flush_i;
`endif

    assign fifo_pop = wb_valid_o & wb_ack_i & ~fifo_empty;

    // Either a result with no room for it, or a result nobody issued.
    assign violation = fu_valid_i & ((fifo_full & ~fifo_pop) | (inflight_q == '0));

    always_comb begin
        inflight_d = inflight_q;
        if (flush_i) begin
            inflight_d = '0;
        end else if (issue_fire && !fu_valid_i) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!issue_fire && fu_valid_i && inflight_q != '0) begin
            inflight_d = inflight_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (violation) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign overflow_o = overflow_q;
    assign count_o    = fifo_count;

    fu_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_din),
        .data_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fu_wb_collector.sv
// Scoreboard bench for fu_wb_collector: directed scenarios, then randomized traffic from a
// 3-cycle FU model checked against a credit/occupancy reference model.
module tb_fu_wb_collector;
    import fu_wb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 3;
`ifdef FU_WB_COLLECTOR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, issue_valid = 1'b0, fu_valid = 1'b0, wb_ack = 1'b0;
    logic        issue_ready, wb_valid, overflow;
    logic [31:0] fu_result = '0, wb_result;
    logic [2:0]  fu_id = '0, wb_id;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fu_wb_collector #(
        .DEPTH      (DEPTH),
        .XLEN       (32),
        .TRANS_ID_W (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .fu_valid_i    (fu_valid),
        .fu_result_i   (fu_result),
        .fu_trans_id_i (fu_id),
        .wb_valid_o    (wb_valid),
        .wb_result_o   (wb_result),
        .wb_trans_id_o (wb_id),
        .wb_ack_i      (wb_ack),
        .count_o       (count),
        .overflow_o    (overflow)
    );

    typedef struct {
        bit          v;
        logic [31:0] res;
        logic [2:0]  id;
    } fu_op_t;

    int           n_cmp = 0;
    int           n_err = 0;
    fu_wb_entry_t exp_q[$];
    fu_op_t       pipe[LAT];
    int           m_cnt = 0;
    int           id_ctr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted writeback must be the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wb_unexpected: got res 0x%0h id %0d with nothing outstanding",
                         wb_result, wb_id);
            end else begin
                fu_wb_entry_t e;
                e = exp_q.pop_front();
                check("wb_result", 64'(wb_result), 64'(e.result));
                check("wb_trans_id", 64'(wb_id), 64'(e.trans_id));
            end
        end
    end

    task automatic drive(input bit iv, input bit fv, input logic [31:0] res,
                         input logic [2:0] id, input bit ack, input bit fl, input bit keep);
        @(posedge clk);
        #1;
        issue_valid = iv;
        fu_valid    = fv;
        fu_result   = res;
        fu_id       = id;
        wb_ack      = ack;
        flush       = fl;
        if (fl) exp_q.delete();
        else if (fv && keep) exp_q.push_back({res, id});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic issue_n(input int n, output int got);
        got = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (issue_ready) got++;
        end
    endtask

    task automatic ret_n(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b1, base * (k + 1), 3'(k), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic ack_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    // One random cycle; the reference tracks occupancy and issued-but-unreturned ops.
    task automatic rand_step(input bit drain);
        bit     iv, fl, ack, fv, exp_ready, exp_wbv, byp_hit;
        int     infl;
        fu_op_t nw;
        fv   = pipe[LAT-1].v;
        fl   = !drain && ($urandom_range(0, 39) == 0);
        iv   = !drain && ($urandom_range(0, 1) == 1);
        ack  = drain || ($urandom_range(0, 3) != 0);
        infl = 0;
        foreach (pipe[i]) if (pipe[i].v) infl++;
        exp_ready = ((int'(DEPTH) - m_cnt - infl) > 0) && !fl;
        byp_hit   = BYP && (m_cnt == 0) && fv && !fl;
        exp_wbv   = ((m_cnt != 0) || byp_hit) && !fl;
        drive(iv, fv, pipe[LAT-1].res, pipe[LAT-1].id, ack, fl, 1'b1);
        check("rnd_issue_ready", 64'(issue_ready), 64'(exp_ready));
        check("rnd_wb_valid", 64'(wb_valid), 64'(exp_wbv));
        check("rnd_count", 64'(count), 64'(m_cnt));
        if (fl) begin
            m_cnt = 0;
            foreach (pipe[i]) pipe[i].v = 1'b0;
        end else begin
            if (!(byp_hit && ack)) m_cnt = m_cnt + int'(fv) - int'((m_cnt != 0) && ack);
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            nw.v   = iv && exp_ready;
            nw.res = $urandom;
            nw.id  = 3'(id_ctr);
            if (nw.v) id_ctr++;
            pipe[0] = nw;
        end
    endtask

    initial begin
        int got;
        foreach (pipe[i]) pipe[i] = '{v: 1'b0, res: '0, id: '0};

        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_wb_result", 64'(wb_result), 64'd0);
        check("rst_wb_id", 64'(wb_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Credit limit, then four results fill the buffer.
        issue_n(6, got);
        check("credit_ready_cycles", 64'(got), 64'd4);
        check("credit_exhausted", 64'(issue_ready), 64'd0);
        idle(3);
        ret_n(4, 32'h11);
        idle(1);
        check("full_count", 64'(count), 64'd4);
        check("full_issue_ready", 64'(issue_ready), 64'd0);

        // Drain in order; credit returns after the first ack.
        ack_n(1);
        check("drain_ready_before", 64'(issue_ready), 64'd0);
        ack_n(1);
        check("drain_ready_after", 64'(issue_ready), 64'd1);
        ack_n(2);
        idle(1);
        check("drain_count", 64'(count), 64'd0);
        check("drain_wb_valid", 64'(wb_valid), 64'd0);

        // Simultaneous push and pop.
        issue_n(3, got);
        check("pp_issued", 64'(got), 64'd3);
        idle(3);
        drive(1'b0, 1'b1, 32'hA1, 3'd4, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'hA2, 3'd5, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'hABCD, 3'd6, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("pp_count", 64'(count), 64'd2);
        ack_n(2);
        idle(1);
        check("pp_drained", 64'(count), 64'd0);
        check("pp_no_overflow", 64'(overflow), 64'd0);

        // Flush with results buffered and in flight; the flushed result must never appear.
        issue_n(4, got);
        idle(3);
        drive(1'b0, 1'b1, 32'hC1, 3'd1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'hC2, 3'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'hDEAD, 3'd3, 1'b0, 1'b1, 1'b1);
        check("flush_cycle_ready", 64'(issue_ready), 64'd0);
        check("flush_cycle_wb_valid", 64'(wb_valid), 64'd0);
        idle(1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_wb_valid", 64'(wb_valid), 64'd0);
        check("flush_issue_ready", 64'(issue_ready), 64'd1);
        issue_n(5, got);
        check("flush_inflight_cleared", 64'(got), 64'd4);
        idle(3);
        ret_n(4, 32'h55);
        ack_n(4);
        idle(1);
        check("flush_recover_count", 64'(count), 64'd0);

        // Overflow is sticky through flush.
        issue_n(4, got);
        idle(3);
        ret_n(4, 32'h66);
        drive(1'b0, 1'b1, 32'hBAD, 3'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_count", 64'(count), 64'd4);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_flush_count", 64'(count), 64'd0);

        // Result with ack into an empty FIFO.
        issue_n(1, got);
        idle(3);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        fu_valid    = 1'b1;
        fu_result   = 32'h7;
        fu_id       = 3'd2;
        wb_ack      = 1'b1;
        flush       = 1'b0;
        exp_q.push_back({32'h7, 3'd2});
        #1;
`ifdef FU_WB_COLLECTOR_BYPASS_EN
        check("byp_wb_valid", 64'(wb_valid), 64'd1);
        check("byp_wb_result", 64'(wb_result), 64'h7);
        check("byp_wb_id", 64'(wb_id), 64'd2);
        @(negedge clk);
        idle(1);
        check("byp_count", 64'(count), 64'd0);
`else
        check("nobyp_wb_valid", 64'(wb_valid), 64'd0);
        @(negedge clk);
        idle(1);
        check("nobyp_count", 64'(count), 64'd1);
        check("nobyp_wb_valid_next", 64'(wb_valid), 64'd1);
        ack_n(1);
        idle(1);
        check("nobyp_drained", 64'(count), 64'd0);
`endif

        // Asynchronous reset mid-burst with three entries buffered.
        issue_n(3, got);
        idle(3);
        ret_n(3, 32'h77);
        idle(1);
        check("pre_rst_count", 64'(count), 64'd3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_wb_valid", 64'(wb_valid), 64'd0);
        check("arst_issue_ready", 64'(issue_ready), 64'd1);
        check("arst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic, then a full drain.
        for (int i = 0; i < 1500; i++) rand_step(1'b0);
        for (int i = 0; i < 40; i++) rand_step(1'b1);
        @(posedge clk);
        #1;
        check("rnd_all_delivered", 64'(exp_q.size()), 64'd0);
        check("rnd_final_count", 64'(count), 64'd0);
        check("rnd_no_overflow", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
